seq_divider_8by4: RTL

Sequential restoring divider: divides an unsigned 8-bit dividend by an unsigned 4-bit divisor and produces an 8-bit quotient and 4-bit remainder. It is the inverse companion of the team's 4x4 combinational array multiplier, and is meant to sit beside it in the same Tiny Tapeout tile. It produces one quotient bit per clock under a start/busy/done handshake. Divide-by-zero is flagged explicitly and never produces undefined outputs.

---
 rtl/seq_divider_pkg.sv | 11 +
 rtl/seq_divider_8by4_div_step.sv | 23 ++
 rtl/seq_divider_8by4.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_divider_pkg;
  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int CNT_W      = $clog2(DIVIDEND_W + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/seq_divider_8by4_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, restore on borrow.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int DSR_W = DIVISOR_W
) (
  input  logic [DSR_W:0]   rem_in,
  input  logic             bit_in,
  input  logic [DSR_W-1:0] divisor,
  output logic [DSR_W:0]   rem_out,
  output logic             q_bit
);
  logic [DSR_W+1:0] shifted;
  logic [DSR_W+1:0] trial;

  // One guard bit above the shifted remainder makes the MSB of trial a clean borrow flag.
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {2'b00, divisor};
    q_bit   = ~trial[DSR_W+1];
    rem_out = q_bit ? trial[DSR_W:0] : shifted[DSR_W:0];
  end
endmodule

// File: rtl/seq_divider_8by4.sv
// Sequential 8-by-4 unsigned restoring divider, one quotient bit per clock.
module seq_divider_8by4
  import seq_divider_pkg::*;
#(
  parameter int DIVIDEND_W = seq_divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = seq_divider_pkg::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W:0]    prem_q, prem_d;
  logic                  dz_pend_q, dz_pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  div_zero_q, div_zero_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  div_step #(.DSR_W(DIVISOR_W)) u_step (
    .rem_in  (prem_q),
    .bit_in  (dvd_q[DIVIDEND_W-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    prem_d      = prem_q;
    dz_pend_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    // A divide-by-zero accepted on the previous edge completes here.
    if (dz_pend_q) begin
      quotient_d  = '1;
      remainder_d = '0;
      div_zero_d  = 1'b1;
      done_d      = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d  = dividend;
          dsr_d  = divisor;
          prem_d = '0;
          cnt_d  = CNT_W'(DIVIDEND_W);
          if (divisor != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            dz_pend_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Quotient bits shift into the dividend register as its bits are consumed.
        prem_d = step_rem;
        dvd_d  = {dvd_q[DIVIDEND_W-2:0], step_q};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = {dvd_q[DIVIDEND_W-2:0], step_q};
          remainder_d = step_rem[DIVISOR_W-1:0];
          div_zero_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      prem_q      <= '0;
      dz_pend_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      prem_q      <= prem_d;
      dz_pend_q   <= dz_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
endmodule
